// File: rtl/sat_pkg.sv
// Shared definitions for the SAT solve sequencer.
// Contents: default sizing, decision-level typedef, controller state enum
// and a saturating-increment helper used by the event counters.
package sat_pkg;

    localparam int unsigned VAR_NUM_DEF = 8;
    localparam int unsigned LVL_W_DEF   = $clog2(VAR_NUM_DEF + 1);
    localparam int unsigned CNT_W_DEF   = 32;
    // Widest counter the saturating helper supports.
    localparam int unsigned SAT_W       = 64;

    typedef logic [LVL_W_DEF-1:0] level_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BCP_WAIT,
        S_DECIDE,
        S_BT_SCAN,
        S_BT_WAIT,
        S_DONE
    } state_e;

    // Increment v, sticking at max_v (the all-ones value of the caller's width).
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        return (v >= max_v) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/bcp_join.sv
// Sticky completion collector for the parallel BCP channels.
// Ports: clk, rst (sync, active-high); clear drops all recorded state;
// en gates acceptance of done pulses; done/conflict are per-channel inputs;
// all_done/any_conflict include the current cycle's accepted pulses so the
// controller can react in the same cycle the last channel reports.
module bcp_join #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [N-1:0] done,
    input  logic [N-1:0] conflict,
    output logic         all_done,
    output logic         any_conflict
);

    logic [N-1:0] done_q, done_d;
    logic         conf_q, conf_d;
    logic [N-1:0] acc_c;

    // Only the first done of each channel counts; its conflict is sampled with it.
    always_comb begin
        acc_c        = en ? (done & ~done_q) : '0;
        all_done     = en & (&(done_q | acc_c));
        any_conflict = conf_q | (|(acc_c & conflict));
        done_d       = clear ? '0 : (done_q | acc_c);
        conf_d       = clear ? 1'b0 : any_conflict;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
            conf_q <= 1'b0;
        end else begin
            done_q <= done_d;
            conf_q <= conf_d;
        end
    end

endmodule

// File: rtl/sat_solver_ctrl.sv
// Solve sequencer: init -> BCP (NUM_BCP channels) -> decide, with chronological
// backtracking over per-level flip bits, reporting SAT/UNSAT.
// Ports: clk, rst (sync, active-high); sat_start/sat/sat_finish/sat_timeout
// external handshake; initial_*, decide_*, bcp_*, backtrack_* engine
// handshakes; decision_level and conflict_count status.
// Optional feature: define SAT_TIMEOUT_EN to abort when the busy-cycle count
// reaches max_cycles (0 disables); otherwise sat_timeout is 0, max_cycles unused.
module sat_solver_ctrl
    import sat_pkg::*;
#(
    parameter int unsigned VAR_NUM = VAR_NUM_DEF,
    parameter int unsigned NUM_BCP = 2,
    parameter int unsigned LVL_W   = $clog2(VAR_NUM + 1),
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sat_start,
    output logic               sat,
    output logic               sat_finish,
    output logic               sat_timeout,
    input  logic [CNT_W-1:0]   max_cycles,
    output logic               initial_request,
    input  logic               initial_finish,
    output logic               decide_request,
    input  logic               decide_done,
    input  logic               decide_none,
    output logic [NUM_BCP-1:0] bcp_request,
    input  logic [NUM_BCP-1:0] bcp_done,
    input  logic [NUM_BCP-1:0] bcp_conflict,
    output logic               backtrack_request,
    output logic [LVL_W-1:0]   backtrack_level,
    input  logic               backtrack_done,
    output logic [LVL_W-1:0]   decision_level,
    output logic [CNT_W-1:0]   conflict_count
);

    state_e               state_q, state_d;
    logic                 sat_q, sat_d;
    logic                 fin_q, fin_d;
    logic                 to_q, to_d;
    logic                 init_req_q, init_req_d;
    logic                 dec_req_q, dec_req_d;
    logic [NUM_BCP-1:0]   bcp_req_q, bcp_req_d;
    logic                 bt_req_q, bt_req_d;
    logic [LVL_W-1:0]     bt_lvl_q, bt_lvl_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [VAR_NUM:0]     flip_q, flip_d;      // bit 0 never set: level 0 has no decision
    logic [CNT_W-1:0]     conf_q, conf_d;
    logic                 join_clear_c, join_en_c, all_done_c, any_conf_c;

`ifdef SAT_TIMEOUT_EN
    logic [CNT_W-1:0]     cyc_q, cyc_d;
`else
    logic                 unused_max_cycles;
    assign unused_max_cycles = ^max_cycles;
`endif

    // Channel dones are accepted only in BCP_WAIT and not alongside our own request.
    assign join_clear_c = (state_q != S_BCP_WAIT);
    assign join_en_c    = (state_q == S_BCP_WAIT) && (bcp_req_q == '0);

    bcp_join #(.N(NUM_BCP)) u_join (
        .clk          (clk),
        .rst          (rst),
        .clear        (join_clear_c),
        .en           (join_en_c),
        .done         (bcp_done),
        .conflict     (bcp_conflict),
        .all_done     (all_done_c),
        .any_conflict (any_conf_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        sat_d      = sat_q;
        fin_d      = fin_q;
        to_d       = to_q;
        init_req_d = 1'b0;
        dec_req_d  = 1'b0;
        bcp_req_d  = '0;
        bt_req_d   = 1'b0;
        bt_lvl_d   = bt_lvl_q;
        level_d    = level_q;
        flip_d     = flip_q;
        conf_d     = conf_q;
`ifdef SAT_TIMEOUT_EN
        cyc_d      = cyc_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (sat_start) begin
                    init_req_d = 1'b1;
                    sat_d      = 1'b0;
                    fin_d      = 1'b0;
                    to_d       = 1'b0;
                    bt_lvl_d   = '0;
                    level_d    = '0;
                    flip_d     = '0;
                    conf_d     = '0;
`ifdef SAT_TIMEOUT_EN
                    cyc_d      = '0;
`endif
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                if (initial_finish) begin
                    bcp_req_d = '1;
                    state_d   = S_BCP_WAIT;
                end
            end
            S_BCP_WAIT: begin
                if (all_done_c) begin
                    if (any_conf_c) begin
                        conf_d  = CNT_W'(sat_inc(SAT_W'(conf_q), SAT_W'({CNT_W{1'b1}})));
                        state_d = S_BT_SCAN;
                    end else begin
                        dec_req_d = 1'b1;
                        state_d   = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                // No free variable, or already at the deepest level: satisfiable.
                if (decide_none || (decide_done && level_q == LVL_W'(VAR_NUM))) begin
                    sat_d   = 1'b1;
                    fin_d   = 1'b1;
                    state_d = S_DONE;
                end else if (decide_done) begin
                    level_d                       = level_q + LVL_W'(1);
                    flip_d[level_q + LVL_W'(1)]   = 1'b0;
                    bcp_req_d                     = '1;
                    state_d                       = S_BCP_WAIT;
                end
            end
            S_BT_SCAN: begin
                if (level_q == '0) begin
                    sat_d   = 1'b0;
                    fin_d   = 1'b1;
                    state_d = S_DONE;
                end else if (flip_q[level_q]) begin
                    // Both polarities tried at this level: pop it.
                    flip_d[level_q] = 1'b0;
                    level_d         = level_q - LVL_W'(1);
                end else begin
                    flip_d[level_q] = 1'b1;
                    bt_lvl_d        = level_q;
                    bt_req_d        = 1'b1;
                    state_d         = S_BT_WAIT;
                end
            end
            S_BT_WAIT: begin
                if (backtrack_done) begin
                    bcp_req_d = '1;
                    state_d   = S_BCP_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SAT_TIMEOUT_EN
        // Budget exhaustion overrides whatever the busy state decided this cycle.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            cyc_d = CNT_W'(sat_inc(SAT_W'(cyc_q), SAT_W'({CNT_W{1'b1}})));
            if (max_cycles != '0 && cyc_d >= max_cycles) begin
                state_d   = S_DONE;
                sat_d     = 1'b0;
                fin_d     = 1'b1;
                to_d      = 1'b1;
                dec_req_d = 1'b0;
                bcp_req_d = '0;
                bt_req_d  = 1'b0;
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sat_q      <= 1'b0;
            fin_q      <= 1'b0;
            to_q       <= 1'b0;
            init_req_q <= 1'b0;
            dec_req_q  <= 1'b0;
            bcp_req_q  <= '0;
            bt_req_q   <= 1'b0;
            bt_lvl_q   <= '0;
            level_q    <= '0;
            flip_q     <= '0;
            conf_q     <= '0;
`ifdef SAT_TIMEOUT_EN
            cyc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sat_q      <= sat_d;
            fin_q      <= fin_d;
            to_q       <= to_d;
            init_req_q <= init_req_d;
            dec_req_q  <= dec_req_d;
            bcp_req_q  <= bcp_req_d;
            bt_req_q   <= bt_req_d;
            bt_lvl_q   <= bt_lvl_d;
            level_q    <= level_d;
            flip_q     <= flip_d;
            conf_q     <= conf_d;
`ifdef SAT_TIMEOUT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    assign sat               = sat_q;
    assign sat_finish        = fin_q;
    assign sat_timeout       = to_q;
    assign initial_request   = init_req_q;
    assign decide_request    = dec_req_q;
    assign bcp_request       = bcp_req_q;
    assign backtrack_request = bt_req_q;
    assign backtrack_level   = bt_lvl_q;
    assign decision_level    = level_q;
    assign conflict_count    = conf_q;

endmodule

// File: tb/tb_sat_solver_ctrl.sv
// Bench for sat_solver_ctrl: directed scenarios plus randomized solve runs
// checked against a level/flip-stack reference model.
module tb_sat_solver_ctrl;

    localparam int VAR_NUM = 8;
    localparam int NUM_BCP = 2;
    localparam int LVL_W   = 4;
    localparam int CNT_W   = 32;
    localparam logic [NUM_BCP-1:0] BCP_ALL = '1;

    logic               clk = 1'b0;
    logic               rst, sat_start, initial_finish, decide_done, decide_none, backtrack_done;
    logic [NUM_BCP-1:0] bcp_done, bcp_conflict;
    logic [CNT_W-1:0]   max_cycles;
    logic               sat, sat_finish, sat_timeout, initial_request, decide_request, backtrack_request;
    logic [NUM_BCP-1:0] bcp_request;
    logic [LVL_W-1:0]   backtrack_level, decision_level;
    logic [CNT_W-1:0]   conflict_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current level, per-level "second polarity tried" bits, conflicts.
    int m_level;
    int m_conf;
    bit m_flip [0:VAR_NUM];

    always #5 clk = ~clk;

    sat_solver_ctrl #(.VAR_NUM(VAR_NUM), .NUM_BCP(NUM_BCP), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sat_start(sat_start), .sat(sat), .sat_finish(sat_finish),
        .sat_timeout(sat_timeout), .max_cycles(max_cycles),
        .initial_request(initial_request), .initial_finish(initial_finish),
        .decide_request(decide_request), .decide_done(decide_done), .decide_none(decide_none),
        .bcp_request(bcp_request), .bcp_done(bcp_done), .bcp_conflict(bcp_conflict),
        .backtrack_request(backtrack_request), .backtrack_level(backtrack_level),
        .backtrack_done(backtrack_done), .decision_level(decision_level),
        .conflict_count(conflict_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sat_start = 0; initial_finish = 0; decide_done = 0; decide_none = 0;
        backtrack_done = 0; bcp_done = '0; bcp_conflict = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic start_run(output logic ir);
        sat_start = 1'b1; step(); sat_start = 1'b0;
        ir = initial_request;
        m_level = 0; m_conf = 0;
        for (int i = 0; i <= VAR_NUM; i++) m_flip[i] = 1'b0;
    endtask

    task automatic finish_init(input int dly);
        repeat (dly) step();
        initial_finish = 1'b1; step(); initial_finish = 1'b0;
    endtask

    // Called in the cycle bcp_request is visible; channel i reports dN cycles later.
    task automatic run_bcp(input int d0, input int d1, input bit c0, input bit c1, output int early);
        int mx;
        mx = (d0 > d1) ? d0 : d1;
        early = 0;
        for (int c = 0; c <= mx; c++) begin
            bcp_done     = {1'(d1 == c), 1'(d0 == c)};
            bcp_conflict = {1'(c1 && d1 == c), 1'(c0 && d0 == c)};
            step();
            if (c < mx && (decide_request || backtrack_request || sat_finish)) early++;
        end
        bcp_done = '0; bcp_conflict = '0;
    endtask

    task automatic do_decide(input int dly, input bit dn, input bit nn, output bit ended);
        repeat (dly) step();
        decide_done = dn; decide_none = nn; step(); decide_done = 0; decide_none = 0;
        if (nn || (dn && m_level == VAR_NUM)) begin
            ended = 1;
            n_cmp++;
            if ({sat_finish, sat, sat_timeout} !== 3'b110) begin
                n_err++; $display("FAIL sat_result: got %b expected 110", {sat_finish, sat, sat_timeout});
            end
        end else begin
            ended = 0;
            m_level++;
            m_flip[m_level] = 1'b0;
            n_cmp++;
            if (bcp_request !== BCP_ALL) begin
                n_err++; $display("FAIL bcp_after_decide: got %b expected %b", bcp_request, BCP_ALL);
            end
        end
        n_cmp++;
        if (decision_level !== LVL_W'(m_level)) begin
            n_err++; $display("FAIL decide_level: got %0d expected %0d", decision_level, m_level);
        end
    endtask

    // Called in the first cycle after the conflicting BCP round completed.
    task automatic resolve_conflict(input int bt_dly, input bit send_done, output bit ended);
        int l, k, cnt;
        bit unsat;
        m_conf++;
        l = m_level; k = 0;
        while (l > 0 && m_flip[l]) begin m_flip[l] = 1'b0; l--; k++; end
        unsat = (l == 0);
        if (!unsat) m_flip[l] = 1'b1;
        m_level = l;
        cnt = 0;
        while (!(backtrack_request || sat_finish) && cnt < 4 * VAR_NUM) begin step(); cnt++; end
        n_cmp++;
        if (cnt != k + 1) begin
            n_err++; $display("FAIL bt_scan_cycles: got %0d expected %0d", cnt, k + 1);
        end
        n_cmp++;
        if (conflict_count !== CNT_W'(m_conf)) begin
            n_err++; $display("FAIL conflict_count: got %0d expected %0d", conflict_count, m_conf);
        end
        n_cmp++;
        if (decision_level !== LVL_W'(m_level)) begin
            n_err++; $display("FAIL bt_decision_level: got %0d expected %0d", decision_level, m_level);
        end
        if (unsat) begin
            ended = 1;
            n_cmp++;
            if ({sat_finish, sat, backtrack_request} !== 3'b100) begin
                n_err++; $display("FAIL unsat_result: got %b expected 100", {sat_finish, sat, backtrack_request});
            end
        end else begin
            ended = 0;
            n_cmp++;
            if (backtrack_request !== 1'b1 || backtrack_level !== LVL_W'(l)) begin
                n_err++; $display("FAIL bt_request: got req=%b lvl=%0d expected req=1 lvl=%0d",
                                  backtrack_request, backtrack_level, l);
            end
            if (send_done) begin
                repeat (bt_dly) step();
                n_cmp++;
                if (backtrack_level !== LVL_W'(l)) begin
                    n_err++; $display("FAIL bt_level_held: got %0d expected %0d", backtrack_level, l);
                end
                backtrack_done = 1'b1; step(); backtrack_done = 1'b0;
                n_cmp++;
                if (bcp_request !== BCP_ALL) begin
                    n_err++; $display("FAIL bcp_after_bt: got %b expected %b", bcp_request, BCP_ALL);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({sat, sat_finish, sat_timeout, initial_request, decide_request, backtrack_request} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 000000",
                {sat, sat_finish, sat_timeout, initial_request, decide_request, backtrack_request});
        end
        n_cmp++;
        if ({bcp_request, backtrack_level, decision_level, conflict_count} !== '0) begin
            n_err++; $display("FAIL reset_buses: got bcp=%b btl=%0d lvl=%0d cc=%0d expected 0",
                bcp_request, backtrack_level, decision_level, conflict_count);
        end
    endtask

    task automatic test_trivial_sat();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        n_cmp++;
        if (ir !== 1'b1) begin n_err++; $display("FAIL init_request: got %b expected 1", ir); end
        step();
        n_cmp++;
        if (initial_request !== 1'b0) begin n_err++; $display("FAIL init_pulse_width: got %b expected 0", initial_request); end
        finish_init(1);
        n_cmp++;
        if (bcp_request !== BCP_ALL) begin n_err++; $display("FAIL bcp_after_init: got %b expected %b", bcp_request, BCP_ALL); end
        run_bcp(1, 2, 0, 0, early);
        n_cmp++;
        if (early !== 0 || decide_request !== 1'b1) begin
            n_err++; $display("FAIL trivial_decide_req: got early=%0d req=%b expected 0/1", early, decide_request);
        end
        do_decide(1, 0, 1, ended);
    endtask

    task automatic test_level0_conflict();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        finish_init(0);
        run_bcp(2, 2, 0, 1, early);
        resolve_conflict(0, 1, ended);
        n_cmp++;
        if (ended !== 1'b1) begin n_err++; $display("FAIL level0_unsat: got %b expected 1", ended); end
    endtask

    task automatic test_skewed();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        finish_init(0);
        run_bcp(1, 6, 0, 0, early);
        n_cmp++;
        if (early !== 0 || decide_request !== 1'b1) begin
            n_err++; $display("FAIL skewed_decide: got early=%0d req=%b expected 0/1", early, decide_request);
        end
        do_decide(0, 1, 1, ended);   // simultaneous done+none: none wins
    endtask

    task automatic test_ignored_inputs();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        finish_init(0);
        // Same cycle as bcp_request: dones ignored, and stray start/decide pulses too.
        sat_start = 1; decide_done = 1; backtrack_done = 1; bcp_done = BCP_ALL;
        step();
        sat_start = 0; decide_done = 0; backtrack_done = 0; bcp_done = '0;
        n_cmp++;
        if ({initial_request, decide_request, backtrack_request, sat_finish} !== 4'b0) begin
            n_err++; $display("FAIL ignored_pulses: got %b expected 0000",
                {initial_request, decide_request, backtrack_request, sat_finish});
        end
        run_bcp(0, 2, 0, 0, early);
        n_cmp++;
        if (decide_request !== 1'b1 || decision_level !== '0) begin
            n_err++; $display("FAIL ignored_then_decide: got req=%b lvl=%0d expected 1/0", decide_request, decision_level);
        end
        do_decide(0, 0, 1, ended);
    endtask

    task automatic test_flip_pop();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        finish_init(0);
        for (int i = 0; i < 2; i++) begin
            run_bcp(1, 1, 0, 0, early);
            do_decide(0, 1, 0, ended);
        end
        for (int i = 0; i < 3; i++) begin
            run_bcp(1, 2, 1, 0, early);
            resolve_conflict(1, 1, ended);
        end
        n_cmp++;
        if (ended !== 1'b1 || conflict_count !== 32'd3) begin
            n_err++; $display("FAIL flip_pop_unsat: got ended=%b cc=%0d expected 1/3", ended, conflict_count);
        end
    endtask

    task automatic test_var_limit();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        finish_init(0);
        for (int i = 0; i <= VAR_NUM; i++) begin
            run_bcp(1, 1, 0, 0, early);
            do_decide(0, 1, 0, ended);
        end
        n_cmp++;
        if (ended !== 1'b1 || decision_level !== LVL_W'(VAR_NUM)) begin
            n_err++; $display("FAIL var_limit_sat: got ended=%b lvl=%0d expected 1/%0d", ended, decision_level, VAR_NUM);
        end
    endtask

    task automatic test_reset_bt_wait();
        logic ir; int early; bit ended;
        do_reset();
        start_run(ir);
        finish_init(0);
        run_bcp(1, 1, 0, 0, early);
        do_decide(0, 1, 0, ended);
        run_bcp(1, 1, 1, 1, early);
        resolve_conflict(0, 0, ended);    // now parked in BT_WAIT
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++;
        if ({sat, sat_finish, sat_timeout, initial_request, decide_request, backtrack_request, bcp_request,
             backtrack_level, decision_level, conflict_count} !== '0) begin
            n_err++; $display("FAIL reset_in_bt_wait: got lvl=%0d btl=%0d cc=%0d req=%b expected all 0",
                decision_level, backtrack_level, conflict_count, backtrack_request);
        end
        start_run(ir);
        n_cmp++;
        if (ir !== 1'b1) begin n_err++; $display("FAIL restart_init: got %b expected 1", ir); end
        finish_init(0);
        run_bcp(2, 1, 0, 0, early);
        do_decide(0, 0, 1, ended);
    endtask

    task automatic test_timeout();
        logic ir; int cnt;
        do_reset();
        max_cycles = 32'd20;
        start_run(ir);
        initial_finish = 1'b1; step(); initial_finish = 1'b0;
        cnt = 1;
        while (!sat_finish && cnt < 60) begin step(); cnt++; end
`ifdef SAT_TIMEOUT_EN
        n_cmp++;
        if (cnt != 20 || {sat_finish, sat, sat_timeout} !== 3'b101) begin
            n_err++; $display("FAIL timeout: got cycles=%0d flags=%b expected 20/101", cnt, {sat_finish, sat, sat_timeout});
        end
`else
        n_cmp++;
        if ({sat_finish, sat_timeout} !== 2'b00) begin
            n_err++; $display("FAIL no_timeout: got %b expected 00", {sat_finish, sat_timeout});
        end
`endif
        max_cycles = '0;
    endtask

    task automatic test_random();
        logic ir; int early, phases; bit ended, cf; int cb, r;
        for (int run = 0; run < 30; run++) begin
            do_reset();
            start_run(ir);
            n_cmp++;
            if (ir !== 1'b1) begin n_err++; $display("FAIL rnd_init_request: got %b expected 1", ir); end
            finish_init($urandom_range(0, 3));
            n_cmp++;
            if (bcp_request !== BCP_ALL) begin n_err++; $display("FAIL rnd_bcp_after_init: got %b", bcp_request); end
            ended = 0; phases = 0;
            while (!ended && phases < 40) begin
                cf = ($urandom_range(0, 99) < 35);
                cb = cf ? $urandom_range(1, 3) : 0;
                run_bcp($urandom_range(1, 5), $urandom_range(1, 5), 1'(cb & 1), 1'((cb >> 1) & 1), early);
                n_cmp++;
                if (early !== 0) begin n_err++; $display("FAIL rnd_early_response: got %0d expected 0", early); end
                if (cf) begin
                    resolve_conflict($urandom_range(0, 3), 1, ended);
                end else begin
                    n_cmp++;
                    if (decide_request !== 1'b1) begin n_err++; $display("FAIL rnd_decide_req: got %b expected 1", decide_request); end
                    r = $urandom_range(0, 99);
                    do_decide($urandom_range(0, 3), (r >= 15) || (r < 5), (r < 15), ended);
                end
                phases++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; sat_start = 0; initial_finish = 0; decide_done = 0; decide_none = 0;
        backtrack_done = 0; bcp_done = '0; bcp_conflict = '0; max_cycles = '0;
        test_reset();
        test_trivial_sat();
        test_level0_conflict();
        test_skewed();
        test_ignored_inputs();
        test_flip_pop();
        test_var_limit();
        test_reset_bt_wait();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
